// File: rtl/camsim_tx.sv
// Camera bus transmitter: free-running cam_clk, 12-bit test-pattern pixels
// and hsync/vsync framing, all slot updates aligned to cam_clk falling edges.
//
// Ports:
//   clk          main clock
//   rst          synchronous active-high reset
//   enable       request frame transmission (sampled at frame boundaries)
//   pattern_sel  test pattern, latched at frame start
//   cam_clk      generated camera clock, period 2*CLK_DIV clk
//   cam_pixel    pixel data, stable across cam_clk rising edges
//   cam_hsync    high during horizontal blanking slots (and idle)
//   cam_vsync    high during vertical blanking lines and idle
//   busy         high while a frame is in progress
//   frame_done   one-clk pulse at the end of each frame
//   frame_count  frames completed since reset, wraps
module camsim_tx #(
   parameter int CLK_DIV  = 2,
   parameter int H_ACTIVE = 320,
   parameter int H_BLANK  = 16,
   parameter int V_ACTIVE = 256,
   parameter int V_BLANK  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [1:0]  pattern_sel,
   output logic        cam_clk,
   output logic [11:0] cam_pixel,
   output logic        cam_hsync,
   output logic        cam_vsync,
   output logic        busy,
   output logic        frame_done,
   output logic [31:0] frame_count
);

   localparam int H_TOTAL = H_ACTIVE + H_BLANK;
   localparam int V_TOTAL = V_ACTIVE + V_BLANK;
   localparam int XW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
   localparam int YW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [XW-1:0] X_MAX = XW'(H_TOTAL - 1);
   localparam logic [YW-1:0] Y_MAX = YW'(V_TOTAL - 1);
   localparam logic [XW-1:0] X_ACT = XW'(H_ACTIVE);
   localparam logic [YW-1:0] Y_ACT = YW'(V_ACTIVE);
   localparam logic [DW-1:0] D_MAX = DW'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      VBLANK
   } state_t;

   state_t        state, state_nx;
   logic [DW-1:0] div;
   logic [XW-1:0] x, x_nx;
   logic [YW-1:0] y, y_nx;
   logic [1:0]    pat, pat_nx;
   logic [11:0]   fc, fc_nx;
   logic [11:0]   pixel_nx, px, py;
   logic          hsync_nx, vsync_nx, busy_nx, done_nx;
   logic [31:0]   count_nx;
   logic          tick, fall, last, start, stop;

   assign tick = (div == D_MAX);
   // cam_clk is 1 and about to toggle: this edge is the 1->0 transition
   assign fall = tick & cam_clk;
   assign last = (x == X_MAX) && (y == Y_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         div         <= '0;
         cam_clk     <= 1'b0;
         state       <= IDLE;
         x           <= '0;
         y           <= '0;
         pat         <= '0;
         fc          <= '0;
         cam_pixel   <= '0;
         cam_hsync   <= 1'b1;
         cam_vsync   <= 1'b1;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         frame_count <= '0;
      end else begin
         div         <= tick ? '0 : div + 1'b1;
         cam_clk     <= cam_clk ^ tick;
         state       <= state_nx;
         x           <= x_nx;
         y           <= y_nx;
         pat         <= pat_nx;
         fc          <= fc_nx;
         cam_pixel   <= pixel_nx;
         cam_hsync   <= hsync_nx;
         cam_vsync   <= vsync_nx;
         busy        <= busy_nx;
         frame_done  <= done_nx;
         frame_count <= count_nx;
      end
   end

   always_comb begin
      state_nx = state;
      x_nx     = x;
      y_nx     = y;
      pat_nx   = pat;
      fc_nx    = fc;
      pixel_nx = cam_pixel;
      hsync_nx = cam_hsync;
      vsync_nx = cam_vsync;
      busy_nx  = busy;
      done_nx  = 1'b0;
      count_nx = frame_count;
      start    = 1'b0;
      stop     = 1'b0;
      px       = '0;
      py       = '0;

      if (fall) begin
         case (state)
            IDLE: start = enable;
            ACTIVE, VBLANK: begin
               if (last) begin
                  done_nx  = 1'b1;
                  count_nx = frame_count + 32'd1;
                  // back-to-back frames: restart on the same fall
                  start    = enable;
                  stop     = !enable;
               end else if (x == X_MAX) begin
                  x_nx = '0;
                  y_nx = y + 1'b1;
               end else begin
                  x_nx = x + 1'b1;
               end
            end
            default: stop = 1'b1;
         endcase

         if (start) begin
            x_nx    = '0;
            y_nx    = '0;
            pat_nx  = pattern_sel;
            // the count already includes a frame ending on this fall
            fc_nx   = count_nx[11:0];
            busy_nx = 1'b1;
         end

         if (stop) begin
            state_nx = IDLE;
            busy_nx  = 1'b0;
            pixel_nx = '0;
            hsync_nx = 1'b1;
            vsync_nx = 1'b1;
         end else if (state != IDLE || start) begin
            px = 12'(x_nx);
            py = 12'(y_nx);
            if (y_nx < Y_ACT) begin
               state_nx = ACTIVE;
               vsync_nx = 1'b0;
               if (x_nx < X_ACT) begin
                  hsync_nx = 1'b0;
                  case (pat_nx)
                     2'd0:    pixel_nx = px;
                     2'd1:    pixel_nx = py;
                     2'd2:    pixel_nx = px + py + fc_nx;
                     default: pixel_nx = (px[3] ^ py[3]) ? 12'hFFF : 12'h000;
                  endcase
               end else begin
                  hsync_nx = 1'b1;
                  pixel_nx = '0;
               end
            end else begin
               state_nx = VBLANK;
               vsync_nx = 1'b1;
               pixel_nx = '0;
               hsync_nx = !(x_nx < X_ACT);
            end
         end
      end
   end

endmodule

// File: tb/tb_camsim_tx.sv
// Randomised bench for camsim_tx: two instances (small frame, 16x16 frame)
// share stimulus and are compared every clk against a slot-index model.
module tb_camsim_tx;

   localparam int CD = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [1:0]  sel = 2'd0;

   logic        ck0, hs0, vs0, busy0, done0;
   logic [11:0] pix0;
   logic [31:0] fcnt0;
   logic        ck1, hs1, vs1, busy1, done1;
   logic [11:0] pix1;
   logic [31:0] fcnt1;

   int n_chk = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   // model state per instance
   int          ha[2] = '{4, 16};
   int          hb[2] = '{2, 2};
   int          va[2] = '{3, 16};
   int          vb[2] = '{1, 1};
   int          n[2];
   int          s[2];
   bit          run[2];
   int          mpat[2];
   int          mfc[2];
   logic [31:0] cnt[2];
   logic        e_ck[2], e_hs[2], e_vs[2], e_busy[2], e_done[2];
   logic [11:0] e_pix[2];

   camsim_tx #(
      .CLK_DIV(CD), .H_ACTIVE(4), .H_BLANK(2),
      .V_ACTIVE(3), .V_BLANK(1)
   ) dut (
      .clk(clk), .rst(rst), .enable(en), .pattern_sel(sel),
      .cam_clk(ck0), .cam_pixel(pix0), .cam_hsync(hs0),
      .cam_vsync(vs0), .busy(busy0), .frame_done(done0),
      .frame_count(fcnt0)
   );

   camsim_tx #(
      .CLK_DIV(CD), .H_ACTIVE(16), .H_BLANK(2),
      .V_ACTIVE(16), .V_BLANK(1)
   ) dut_big (
      .clk(clk), .rst(rst), .enable(en), .pattern_sel(sel),
      .cam_clk(ck1), .cam_pixel(pix1), .cam_hsync(hs1),
      .cam_vsync(vs1), .busy(busy1), .frame_done(done1),
      .frame_count(fcnt1)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
   endtask

   function automatic int f_pix(int p, int x, int y, int f);
      case (p)
         0: return x % 4096;
         1: return y % 4096;
         2: return (x + y + f) % 4096;
         default: return (((x / 8) + (y / 8)) % 2 == 1) ? 4095 : 0;
      endcase
   endfunction

   task automatic model_step(input int i);
      int  ht, tot, x, y;
      bit  st;
      ht  = ha[i] + hb[i];
      tot = ht * (va[i] + vb[i]);
      st  = 1'b0;
      e_done[i] = 1'b0;
      if (rst) begin
         n[i] = 0; s[i] = 0; run[i] = 1'b0; cnt[i] = '0;
      end else begin
         n[i]++;
         if (n[i] % (2 * CD) == 0) begin
            if (run[i]) begin
               s[i]++;
               if (s[i] == tot) begin
                  e_done[i] = 1'b1;
                  cnt[i]    = cnt[i] + 1;
                  run[i]    = en;
                  st        = en;
               end
            end else begin
               st = en;
            end
         end
         if (st) begin
            run[i]  = 1'b1;
            s[i]    = 0;
            mpat[i] = int'(sel);
            mfc[i]  = int'(cnt[i] % 4096);
         end
      end
      e_ck[i]   = ((n[i] / CD) % 2) == 1;
      e_busy[i] = run[i];
      if (!run[i]) begin
         e_pix[i] = '0; e_hs[i] = 1'b1; e_vs[i] = 1'b1;
      end else begin
         x = s[i] % ht;
         y = s[i] / ht;
         e_vs[i] = (y >= va[i]);
         e_hs[i] = (x >= ha[i]);
         if (y < va[i] && x < ha[i])
            e_pix[i] = 12'(f_pix(mpat[i], x, y, mfc[i]));
         else
            e_pix[i] = '0;
      end
   endtask

   always @(posedge clk) begin
      model_step(0);
      model_step(1);
   end

   task automatic chk_inst(input int i, input logic ck, input logic [11:0] p,
                           input logic h, input logic v, input logic b,
                           input logic d, input logic [31:0] f);
      check($sformatf("d%0d.cam_clk", i), 32'(ck), 32'(e_ck[i]));
      check($sformatf("d%0d.pixel", i), 32'(p), 32'(e_pix[i]));
      check($sformatf("d%0d.hsync", i), 32'(h), 32'(e_hs[i]));
      check($sformatf("d%0d.vsync", i), 32'(v), 32'(e_vs[i]));
      check($sformatf("d%0d.busy", i), 32'(b), 32'(e_busy[i]));
      check($sformatf("d%0d.done", i), 32'(d), 32'(e_done[i]));
      check($sformatf("d%0d.count", i), f, cnt[i]);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk_inst(0, ck0, pix0, hs0, vs0, busy0, done0, fcnt0);
         chk_inst(1, ck1, pix1, hs1, vs1, busy1, done1, fcnt1);
      end
   end

   task automatic wait_start(input int i);
      bit ok = 1'b0;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clk);
         ok = run[i];
      end
      check("timeout_start", 32'(ok), 32'd1);
   endtask

   task automatic wait_slot(input int i, input int t);
      bit ok = 1'b0;
      for (int k = 0; k < 2000 && !ok; k++) begin
         @(negedge clk);
         ok = run[i] && s[i] == t;
      end
      check("timeout_slot", 32'(ok), 32'd1);
   endtask

   task automatic wait_frames(input int i, input int c);
      int got = 0;
      for (int k = 0; k < 4000 && got < c; k++) begin
         @(negedge clk);
         if (e_done[i]) got++;
      end
      check("timeout_frames", 32'(got), 32'(c));
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int k = 0; k < 3000 && !ok; k++) begin
         @(negedge clk);
         ok = !run[0] && !run[1];
      end
      check("timeout_idle", 32'(ok), 32'd1);
   endtask

   initial begin
      @(negedge clk);
      chk_en = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("idle_count", fcnt0, 32'd0);
      check("idle_busy", 32'(busy0), 32'd0);

      // one frame of pattern 0
      sel = 2'd0; en = 1'b1;
      wait_start(0);
      en = 1'b0;
      wait_idle();
      check("t2_count", fcnt0, 32'd1);

      // three back-to-back frames of pattern 2
      sel = 2'd2; en = 1'b1;
      wait_frames(0, 2);
      en = 1'b0;
      wait_idle();
      check("t3_count", fcnt0, 32'd4);

      // pattern/enable change mid-frame at slot (2,1)
      sel = 2'd0; en = 1'b1;
      wait_slot(0, 8);
      sel = 2'd1; en = 1'b0;
      wait_idle();
      en = 1'b1;
      wait_start(0);
      en = 1'b0;
      wait_idle();
      check("t4_count", fcnt0, 32'd6);

      // checkerboard on the 16x16 instance
      sel = 2'd3; en = 1'b1;
      wait_slot(1, 7);
      en = 1'b0;
      check("t5_p7_0", 32'(pix1), 32'h000);
      wait_slot(1, 8);
      check("t5_p8_0", 32'(pix1), 32'hFFF);
      wait_slot(1, 8 * 18 + 8);
      check("t5_p8_8", 32'(pix1), 32'h000);
      wait_idle();

      // reset mid-line at slot (2,1)
      sel = 2'($urandom); en = 1'b1;
      wait_slot(0, 8);
      rst = 1'b1;
      @(negedge clk);
      check("t6_clk", 32'(ck0), 32'd0);
      check("t6_pix", 32'(pix0), 32'd0);
      check("t6_hs", 32'(hs0), 32'd1);
      check("t6_vs", 32'(vs0), 32'd1);
      check("t6_busy", 32'(busy0), 32'd0);
      check("t6_count", fcnt0, 32'd0);
      rst = 1'b0;
      wait_start(0);
      en = 1'b0;
      wait_idle();

      // random enable / pattern activity
      repeat (40) begin
         sel = 2'($urandom);
         en  = 1'($urandom_range(0, 1));
         repeat ($urandom_range(1, 40)) @(negedge clk);
      end
      en = 1'b0;
      wait_idle();
      repeat (4) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
